seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Word-level controller for the serial pattern detector. It accepts a parallel data word and a pattern over a valid/ready handshake, and shifts the word out MSB-first into an internal overlapping pattern matcher, one bit per clock. It counts the matches and returns the count over a second valid/ready handshake. It sequences the bit-serial detection datapath so upstream logic can work in whole words.

## Interface
Parameters:
- WORD_W, 16, data word width in bits; must be ≥ PAT_W.
- PAT_W, 4, pattern length in bits; must be ≥ 2.
- CNT_W, 5, match counter width; must be ≥ clog2(WORD_W+1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word/pattern valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WORD_W  word to scan, MSB shifted first.
- pat  input  PAT_W  pattern to detect; pat[PAT_W-1] is the first bit in time.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_count  output  CNT_W  number of matches in the word.
- match_pulse  output  1  one-cycle strobe per match.
- busy  output  1  high in SHIFT or REPORT.

## Operation
FSM states are IDLE, SHIFT and REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid, it latches in_data into the shift register and pat into pat_reg.
  - It clears hist (PAT_W bits), the fill counter, bit_cnt and the match count, then moves to SHIFT.
- SHIFT, every cycle:
  - b = shreg MSB.
  - shreg shifts left.
  - hist_next = {hist[PAT_W-2:0], b}.
  - fill saturates at PAT_W.
  - bit_cnt increments.
  - Match when fill_next ≥ PAT_W and hist_next == pat_reg. A match increments the count and sets match_pulse for the next cycle.
  - After the WORD_W-th bit it moves to REPORT.
- REPORT:
  - out_valid=1; out_count is held stable.
  - On out_ready it moves to IDLE.
- Matching behaviour:
  - Matches overlap: hist is not cleared on a match.
  - History is cleared per word; matches never span two words.
  - The maximum count is WORD_W-PAT_W+1, so the counter cannot overflow. No saturation logic is needed.
- Input sampling:
  - in_ready=0 in SHIFT and REPORT.
  - in_data and pat are sampled only at acceptance. Changes to them afterwards have no effect on the word in flight.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_count=0, match_pulse=0, busy=0, all internal registers cleared.
- Reset takes effect immediately when asserted, independent of clk.
- Reset mid-SHIFT or mid-REPORT discards the word and its count. There is no out_valid for it.
- Acceptance edge E0 (in_valid & in_ready): state becomes SHIFT and busy=1.
- Bit k (0-based) is consumed at edge E(k+1).
- match_pulse is high for the cycle after the edge that consumed the completing bit.
- out_valid rises after edge E(WORD_W). Minimum accept-to-result latency is WORD_W+1 cycles.
- A match completed by the last bit pulses in the first out_valid cycle.
- The handshake completes on an edge where out_valid & out_ready. The next cycle is IDLE with in_ready=1.
- Minimum word period is WORD_W+2 cycles.
- in_valid high during REPORT is not accepted, even when out_ready is also high. It is accepted one cycle later in IDLE.
- out_count holds its value after the handshake until the next acceptance clears it.

## Test plan
Defaults are WORD_W=16, PAT_W=4, CNT_W=5.
- **Overlapping matches:** pat=4'b1011, in_data=16'hB6DB, out_ready=1 → match_pulse after edges E4, E7, E10, E13, E16; out_valid after E16 with out_count=5.
- **All-zero word, all-zero pattern:** pat=4'b0000, in_data=16'h0000 → 13 match_pulses, first after E4; out_count=13.
- **No match and word isolation:**
  - pat=4'b1111, in_data=16'h0000 → out_count=0, no pulses.
  - Then pat=4'b1011, words 16'h0005 then 16'h8000 → both out_count=0, because history does not carry across words.
- **Backpressure:** pat=4'b1011, in_data=16'hB6DB, out_ready=0 for 5 cycles after out_valid → out_valid=1, out_count=5 stable, in_ready=0 throughout; an in_valid held meanwhile is accepted only after the handshake plus one cycle.
- **Reset mid-operation:** assert rst asynchronously between E8 and E9 → in_ready=1, busy=0, out_valid=0, out_count=0, match_pulse=0 immediately, with no out_valid afterwards; the next word scans correctly.
- **Pattern latched:** change pat after E0 → count reflects the pattern sampled at E0.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Word-level controller that shifts a parallel word MSB-first through an
// overlapping pattern matcher and returns the match count over valid/ready.
module seq_scan_ctrl #(
   parameter int WORD_W = 16,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic [PAT_W-1:0]  pat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              match_pulse,
   output logic              busy
);

   localparam int BW = $clog2(WORD_W + 1);
   localparam int FW = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

   state_t            state, state_next;
   logic [WORD_W-1:0] shreg;
   logic [PAT_W-1:0]  pat_reg;
   logic [PAT_W-1:0]  hist, hist_next;
   logic [FW-1:0]     fill, fill_next;
   logic [BW-1:0]     bit_cnt;
   logic [CNT_W-1:0]  count;
   logic              accept;
   logic              match;
   logic              last_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      hist_next  = {hist[PAT_W-2:0], shreg[WORD_W-1]};
      fill_next  = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
      last_bit   = (bit_cnt == BW'(WORD_W - 1));
      // Fill gating suppresses matches against the cleared history at word start.
      match      = (state == SHIFT) && (fill_next >= FW'(PAT_W)) &&
                   (hist_next == pat_reg);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) state_next = REPORT;
         end
         REPORT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         pat_reg     <= '0;
         hist        <= '0;
         fill        <= '0;
         bit_cnt     <= '0;
         count       <= '0;
         match_pulse <= 1'b0;
      end else begin
         match_pulse <= match;
         if (accept) begin
            shreg   <= in_data;
            pat_reg <= pat;
            hist    <= '0;
            fill    <= '0;
            bit_cnt <= '0;
            count   <= '0;
         end else if (state == SHIFT) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            hist    <= hist_next;
            fill    <= fill_next;
            bit_cnt <= bit_cnt + BW'(1);
            if (match) count <= count + CNT_W'(1);
         end
      end
   end

   assign out_count = count;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: table of words with hand-computed counts
// and per-edge pulse masks, plus backpressure and mid-scan reset sequences.
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  pat;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_count;
   logic        match_pulse;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .pat(pat),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .match_pulse(match_pulse), .busy(busy)
   );

   // mask bit k-1 set means match_pulse expected high after edge Ek
   typedef struct {
      logic [15:0] data;
      logic [3:0]  pat;
      logic [4:0]  cnt;
      logic [15:0] mask;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at 1 time unit after a rising edge with the DUT idle.
   task automatic run_word(input string nm, input logic [15:0] d, input logic [3:0] p,
                           input logic [4:0] exp_cnt, input logic [15:0] exp_mask);
      logic [15:0] mask;
      logic        early;
      check({nm, " idle_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_data   = d;
      pat       = p;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = ~d;
      pat      = ~p;
      check({nm, " e0_busy_ready"}, {30'd0, busy, in_ready}, 32'b10);
      mask  = '0;
      early = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         mask[k-1] = match_pulse;
         if (k < 16 && out_valid) early = 1'b1;
      end
      check({nm, " early_valid"}, {31'd0, early}, 32'd0);
      check({nm, " pulse_mask"}, {16'd0, mask}, {16'd0, exp_mask});
      check({nm, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, " out_count"}, {27'd0, out_count}, {27'd0, exp_cnt});
      tick();
      check({nm, " post_hs rdy/vld/busy"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
      check({nm, " count_hold"}, {27'd0, out_count}, {27'd0, exp_cnt});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] mask;
      logic        seen;

      vecs[0] = '{16'hB6DB, 4'b1011, 5'd5,  16'h9248};
      vecs[1] = '{16'h0000, 4'b0000, 5'd13, 16'hFFF8};
      vecs[2] = '{16'h0000, 4'b1111, 5'd0,  16'h0000};
      vecs[3] = '{16'h0005, 4'b1011, 5'd0,  16'h0000};
      vecs[4] = '{16'h8000, 4'b1011, 5'd0,  16'h0000};
      vecs[5] = '{16'hFFFF, 4'b1111, 5'd13, 16'hFFF8};
      vecs[6] = '{16'hAAAA, 4'b1010, 5'd7,  16'hAAA8};
      vecs[7] = '{16'h000B, 4'b1011, 5'd1,  16'h8000};
      vecs[8] = '{16'hB000, 4'b1011, 5'd1,  16'h0008};
      vecs[9] = '{16'h9249, 4'b1001, 5'd5,  16'h9248};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      pat       = '0;
      out_ready = 1'b0;
      #12;
      check("reset outputs", {27'd0, in_ready, out_valid, match_pulse, busy, |out_count},
            32'b10000);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++)
         run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].pat, vecs[i].cnt, vecs[i].mask);

      // Backpressure: result held while out_ready low; queued word waits.
      in_valid  = 1'b1;
      in_data   = 16'hB6DB;
      pat       = 4'b1011;
      out_ready = 1'b0;
      tick();
      in_data = 16'h000B;
      pat     = 4'b1011;
      for (int k = 1; k <= 16; k++) tick();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp hold%0d vld/rdy", c), {30'd0, out_valid, in_ready}, 32'b10);
         check($sformatf("bp hold%0d count", c), {27'd0, out_count}, 32'd5);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp after_hs rdy/busy", {30'd0, in_ready, busy}, 32'b10);
      tick();
      check("bp queued_accept busy", {31'd0, busy}, 32'd1);
      in_valid = 1'b0;
      pat      = 4'b0000;
      for (int k = 1; k <= 16; k++) tick();
      check("bp second vld", {31'd0, out_valid}, 32'd1);
      check("bp second count", {27'd0, out_count}, 32'd1);
      tick();

      // Reset between E8 and E9 discards the word.
      in_valid = 1'b1;
      in_data  = 16'hB6DB;
      pat      = 4'b1011;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      check("pre_reset count", {27'd0, out_count}, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("async reset outputs",
            {27'd0, in_ready, out_valid, match_pulse, busy, |out_count}, 32'b10000);
      #3 rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (out_valid || busy) seen = 1'b1;
      end
      check("no result after reset", {31'd0, seen}, 32'd0);
      run_word("post_reset", 16'hB6DB, 4'b1011, 5'd5, 16'h9248);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
